// File: rtl/alu_sched.sv
// alu_sched: round-robin arbiter sharing one 8-bit ALU among NREQ clients.
// One op in flight; registered tagged response with backpressure.
module alu_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_din1,
  input  logic [8*NREQ-1:0] req_din2,
  input  logic [3*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [7:0]        rsp_dout,
  input  logic              rsp_ready,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nx;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic [NREQ-1:0] gnt_oh;
  logic            gnt_any;
  int              idx;

  logic [7:0]      sel_a, sel_b;
  logic [2:0]      sel_op;

  logic [ID_W-1:0] lat_id;
  logic [7:0]      lat_a, lat_b;
  logic [2:0]      lat_op;
  logic [7:0]      alu_y;

  logic            accept;
  logic            load_rsp;
  logic            rsp_fire;

  // first valid requester at or above ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any      = 1'b1;
        gnt_id       = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

  // operand mux for the granted requester
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a  = req_din1[8*i +: 8];
        sel_b  = req_din2[8*i +: 8];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

  // pointer moves just past the winner
  always_comb begin
    if (int'(gnt_id) == NREQ - 1) ptr_nx = '0;
    else ptr_nx = gnt_id + 1'b1;
  end

  // next-state and handshake decode
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    load_rsp  = 1'b0;
    rsp_fire  = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          req_ready = gnt_oh;
          accept    = 1'b1;
          state_nx  = EXEC;
        end
      end
      EXEC: begin
        load_rsp = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ALU on the latched operands
  always_comb begin
    alu_y = '0;
    unique case (lat_op)
      3'b000: alu_y = ~lat_a;
      3'b001: alu_y = lat_a | lat_b;
      3'b010: alu_y = lat_a ^ lat_b;
      3'b011: alu_y = lat_a & lat_b;
      3'b100: alu_y = {4'h0, lat_a[3:0]} * {4'h0, lat_b[3:0]};
      3'b101: alu_y = lat_a + lat_b;
      3'b110: alu_y = lat_a - lat_b;
      default: alu_y = 8'h00;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  // request latch and arbitration pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      lat_id <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
    end else if (accept) begin
      ptr    <= ptr_nx;
      lat_id <= gnt_id;
      lat_a  <= sel_a;
      lat_b  <= sel_b;
      lat_op <= sel_op;
    end
  end

  // registered response channel and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_dout  <= '0;
      ops_done  <= '0;
    end else begin
      if (load_rsp) begin
        rsp_valid <= 1'b1;
        rsp_id    <= lat_id;
        rsp_dout  <= alu_y;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for the shared-ALU scheduler.
// Expected responses are queued at stimulus time and popped on output.
module tb_alu_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_din1;
  logic [8*NREQ-1:0] req_din2;
  logic [3*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_dout;
  logic              rsp_ready;
  logic [15:0]       ops_done;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      d;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_exp = 0;
  int   cyc = 0;

  alu_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_din1(req_din1),
    .req_din2(req_din2),
    .req_op(req_op),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_dout(rsp_dout),
    .rsp_ready(rsp_ready),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [7:0] model(logic [2:0] op, logic [7:0] a,
                                       logic [7:0] b);
    int p;
    case (op)
      3'd0: return ~a;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a & b;
      3'd4: begin
        p = (int'(a) % 16) * (int'(b) % 16);
        return 8'(p);
      end
      3'd5: return 8'((int'(a) + int'(b)) % 256);
      3'd6: return 8'((int'(a) - int'(b) + 256) % 256);
      default: return 8'h00;
    endcase
  endfunction

  task automatic accept_one(input int i, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            output logic [NREQ-1:0] rdy);
    req_op[3*i +: 3]   = op;
    req_din1[8*i +: 8] = a;
    req_din2[8*i +: 8] = b;
    req_valid[i]       = 1'b1;
    #1 rdy = req_ready;
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic collect(output logic [ID_W-1:0] id, output logic [7:0] d,
                         output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    lat = rsp_valid ? n : -1;
    id  = rsp_id;
    d   = rsp_dout;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_din1  = '0;
    req_din2  = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL por_req_ready got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_dout !== 8'h00 ||
        ops_done !== 16'h0) begin
      errors++;
      $display("FAIL por_outputs got v=%b id=%0d d=%h n=%0d want 0", rsp_valid,
               rsp_id, rsp_dout, ops_done);
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_fairness();
    int t[7];
    logic [ID_W-1:0] id;
    logic [7:0] d;
    int lat;
    exp_t e;
    int ids[7] = '{0, 1, 2, 3, 0, 1, 3};
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]   = 3'd5;
      req_din1[8*i +: 8] = 8'(i * 3 + 1);
      req_din2[8*i +: 8] = 8'h10;
    end
    for (int k = 0; k < 5; k++)
      sbq.push_back('{ID_W'(ids[k]), model(3'd5, 8'(ids[k] * 3 + 1), 8'h10)});
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      collect(id, d, lat);
      t[k] = cyc;
      done_exp++;
      if (k == 4) begin
        req_valid = 4'b1010;
        for (int m = 5; m < 7; m++)
          sbq.push_back('{ID_W'(ids[m]),
                          model(3'd5, 8'(ids[m] * 3 + 1), 8'h10)});
      end
      e = sbq.pop_front();
      checks++;
      if (lat < 0 || id !== e.id || d !== e.d) begin
        errors++;
        $display("FAIL fair_rsp%0d got id=%0d d=%h lat=%0d want id=%0d d=%h",
                 k, id, d, lat, e.id, e.d);
      end
      if (k > 0 && k < 5) begin
        checks++;
        if (t[k] - t[k-1] != 3) begin
          errors++;
          $display("FAIL fair_gap%0d got %0d want 3", k, t[k] - t[k-1]);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy;
    logic [ID_W-1:0] id;
    logic [7:0] d;
    int lat;
    exp_t e;
    @(negedge clk);
    sbq.push_back('{2'd2, 8'h10});
    accept_one(2, 3'b101, 8'hF0, 8'h20, rdy);
    checks++;
    if (rdy !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready got %b want 0100", rdy);
    end
    collect(id, d, lat);
    done_exp++;
    e = sbq.pop_front();
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL single_latency got %0d want 2", lat);
    end
    checks++;
    if (id !== e.id || d !== e.d) begin
      errors++;
      $display("FAIL single_rsp got id=%0d d=%h want id=%0d d=%h", id, d,
               e.id, e.d);
    end
  endtask

  task automatic test_opcodes();
    logic [NREQ-1:0] rdy;
    logic [ID_W-1:0] id;
    logic [7:0] d;
    int lat;
    exp_t e;
    int         rq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [2:0] op[8] = '{3'd6, 3'd4, 3'd0, 3'd7, 3'd1, 3'd2, 3'd3, 3'd5};
    logic [7:0] a[8]  = '{8'h05, 8'hAB, 8'h3C, 8'hFF,
                          8'h0F, 8'hFF, 8'hCC, 8'hFF};
    logic [7:0] b[8]  = '{8'h07, 8'hCD, 8'h99, 8'hFF,
                          8'h30, 8'h0F, 8'hAA, 8'h01};
    logic [7:0] x[8]  = '{8'hFE, 8'h8F, 8'hC3, 8'h00,
                          8'h3F, 8'hF0, 8'h88, 8'h00};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sbq.push_back('{ID_W'(rq[k]), x[k]});
      accept_one(rq[k], op[k], a[k], b[k], rdy);
      collect(id, d, lat);
      done_exp++;
      e = sbq.pop_front();
      checks++;
      if (lat != 2 || id !== e.id || d !== e.d) begin
        errors++;
        $display("FAIL op%0d got id=%0d d=%h lat=%0d want id=%0d d=%h lat=2",
                 op[k], id, d, lat, e.id, e.d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] rdy;
    logic [ID_W-1:0] id;
    logic [7:0] d;
    int lat;
    exp_t e;
    logic [15:0] od;
    @(negedge clk);
    rsp_ready = 1'b0;
    sbq.push_back('{2'd3, 8'hFF});
    accept_one(3, 3'd2, 8'hA5, 8'h5A, rdy);
    collect(id, d, lat);
    e = sbq.pop_front();
    checks++;
    if (lat != 2 || id !== e.id || d !== e.d) begin
      errors++;
      $display("FAIL bp_rsp got id=%0d d=%h lat=%0d want id=%0d d=%h",
               id, d, lat, e.id, e.d);
    end
    od = ops_done;
    checks++;
    if (int'(od) != done_exp) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", od, done_exp);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_dout !== e.d ||
          req_ready !== 4'b0000 || ops_done !== 16'(done_exp)) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b id=%0d d=%h rdy=%b n=%0d", k,
                 rsp_valid, rsp_id, rsp_dout, req_ready, ops_done);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    done_exp++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== 16'(done_exp)) begin
      errors++;
      $display("FAIL bp_release got v=%b n=%0d want v=0 n=%0d", rsp_valid,
               ops_done, done_exp);
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [NREQ-1:0] rdy;
    logic [ID_W-1:0] id;
    logic [7:0] d;
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    accept_one(1, 3'd1, 8'h0F, 8'hF0, rdy);
    collect(id, d, lat);
    checks++;
    if (lat != 2 || d !== 8'hFF) begin
      errors++;
      $display("FAIL rr_pre got d=%h lat=%0d want d=ff lat=2", d, lat);
    end
    req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_dout !== 8'h00 ||
        ops_done !== 16'h0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rr_async got v=%b id=%0d d=%h n=%0d rdy=%b", rsp_valid,
               rsp_id, rsp_dout, ops_done, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b0;
    done_exp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_idle%0d got v=%b rdy=%b want 0", k, rsp_valid,
                 req_ready);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [NREQ-1:0] rdy;
    logic [ID_W-1:0] id;
    logic [7:0] d;
    int lat;
    exp_t e;
    @(negedge clk);
    accept_one(1, 3'd5, 8'h01, 8'h01, rdy);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL re_norsp%0d got v=%b want 0", k, rsp_valid);
      end
    end
    req_op[2:0]    = 3'd5;
    req_din1[7:0]  = 8'h11;
    req_din2[7:0]  = 8'h22;
    req_valid      = 4'b1011;
    sbq.push_back('{2'd0, 8'h33});
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL re_grant got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    collect(id, d, lat);
    e = sbq.pop_front();
    checks++;
    if (lat != 2 || id !== e.id || d !== e.d) begin
      errors++;
      $display("FAIL re_rsp got id=%0d d=%h lat=%0d want id=%0d d=%h",
               id, d, lat, e.id, e.d);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_opcodes();
    test_backpressure();
    test_reset_mid_resp();
    test_reset_mid_exec();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
